// File: rtl/div_pkg.sv
// Shared constants and state encoding for the iterative restoring divider.
package div_pkg;

   localparam int DIV_W    = 32;
   localparam int DIV_ITER = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2
   } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {rem,quo} left, trial-subtract the divisor, keep or restore.
module div_step
   import div_pkg::*;
#(
   parameter int W = DIV_W
) (
   input  logic [W-1:0] rem,
   input  logic [W-1:0] quo,
   input  logic [W:0]   dvs,
   output logic [W-1:0] rem_nx,
   output logic [W-1:0] quo_nx
);

   logic [W:0] rem_sh;
   logic [W:0] diff;
   logic       ge;

   // rem is always below dvs, so the shifted value fits in W+1 bits and the kept value in W bits
   assign rem_sh = {rem, quo[W-1]};
   assign ge     = (rem_sh >= dvs);
   assign diff   = rem_sh - dvs;
   assign rem_nx = W'(ge ? diff : rem_sh);
   assign quo_nx = {quo[W-2:0], ge};

endmodule

// File: rtl/div_unit.sv
// Signed 32-bit iterative divider: magnitude restoring divide, then sign fix-up into hidiv/lodiv.
// state | meaning
// IDLE  | waiting for start; b=0 start pulses divzero and stays here
// CALC  | one restoring step per cycle, DIV_ITER cycles
// FIX   | apply quotient/remainder signs, load outputs, pulse done
module div_unit
   import div_pkg::*;
#(
   parameter int W = DIV_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] hidiv,
   output logic [W-1:0] lodiv,
   output logic         busy,
   output logic         done,
   output logic         divzero
);

   localparam int CW = $clog2(DIV_ITER);

   div_state_e     state_q, state_d;
   logic [CW-1:0]  cnt_q;
   logic [W-1:0]   rem_q, quo_q;
   logic [W:0]     dvs_q;
   logic           sign_q, sign_r;
   logic [W-1:0]   rem_nx, quo_nx;
   logic [W:0]     a_mag, b_mag;
   logic           last_iter;

   // 33-bit magnitudes keep |0x80000000| exact
   assign a_mag     = a[W-1] ? ((W+1)'(0) - {a[W-1], a}) : {a[W-1], a};
   assign b_mag     = b[W-1] ? ((W+1)'(0) - {b[W-1], b}) : {b[W-1], b};
   assign last_iter = (cnt_q == CW'(DIV_ITER - 1));

   div_step #(.W(W)) u_step (
      .rem    (rem_q),
      .quo    (quo_q),
      .dvs    (dvs_q),
      .rem_nx (rem_nx),
      .quo_nx (quo_nx)
   );

   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      case (state_q)
         ST_IDLE: if (start && (b != '0)) state_d = ST_CALC;
         ST_CALC: begin
            busy = 1'b1;
            if (last_iter) state_d = ST_FIX;
         end
         ST_FIX: begin
            busy    = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         sign_q  <= 1'b0;
         sign_r  <= 1'b0;
         hidiv   <= '0;
         lodiv   <= '0;
         done    <= 1'b0;
         divzero <= 1'b0;
      end else begin
         state_q <= state_d;
         done    <= 1'b0;
         divzero <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  if (b == '0) begin
                     divzero <= 1'b1;
                  end else begin
                     rem_q  <= '0;
                     quo_q  <= W'(a_mag);
                     dvs_q  <= b_mag;
                     sign_q <= a[W-1] ^ b[W-1];
                     sign_r <= a[W-1];
                     cnt_q  <= '0;
                  end
               end
            end
            ST_CALC: begin
               rem_q <= rem_nx;
               quo_q <= quo_nx;
               cnt_q <= cnt_q + 1'b1;
            end
            ST_FIX: begin
               lodiv <= sign_q ? (W'(0) - quo_q) : quo_q;
               hidiv <= sign_r ? (W'(0) - rem_q) : rem_q;
               done  <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: vector table, random operands against a signed-arithmetic model, corner sequences.
module tb_div_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic [31:0] hidiv, lodiv;
   logic        busy, done, divzero;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   div_unit #(.W(32)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .a       (a),
      .b       (b),
      .hidiv   (hidiv),
      .lodiv   (lodiv),
      .busy    (busy),
      .done    (done),
      .divzero (divzero)
   );

   typedef struct {
      logic [31:0] va;
      logic [31:0] vb;
      logic [31:0] q;
      logic [31:0] r;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference: truncating signed division in wide arithmetic, remainder follows dividend sign
   function automatic logic [63:0] model(input logic [31:0] ta, input logic [31:0] tb2);
      longint sa, sb, q, r;
      logic [63:0] uq, ur;
      sa = longint'($signed(ta));
      sb = longint'($signed(tb2));
      q  = sa / sb;
      r  = sa % sb;
      uq = q;
      ur = r;
      return {ur[31:0], uq[31:0]};
   endfunction

   always @(negedge clk) begin
      if (reset) begin
         checks++;
         if (done && divzero) begin
            errors++;
            $display("FAIL done_divzero_overlap: got done=1 divzero=1, expected not both");
         end
      end
   end

   task automatic issue(input logic [31:0] ta, input logic [31:0] tb2);
      @(negedge clk);
      a = ta;
      b = tb2;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Returns the edge number (start edge = 1) on which done rose; 99 on timeout
   task automatic wait_done(input int first, output int edges);
      edges = first;
      while (edges < 60) begin
         @(posedge clk);
         edges++;
         #1;
         if (done) return;
      end
      edges = 99;
   endtask

   task automatic run_vec(input logic [31:0] ta, input logic [31:0] tb2,
                          input logic [31:0] eq, input logic [31:0] er);
      int e;
      issue(ta, tb2);
      check("busy_after_start", 64'(busy), 64'd1);
      wait_done(1, e);
      check("latency", 64'(e), 64'd34);
      check("lodiv", 64'(lodiv), 64'(eq));
      check("hidiv", 64'(hidiv), 64'(er));
      check("divzero_on_done", 64'(divzero), 64'd0);
      @(posedge clk);
      #1;
      check("done_one_cycle", 64'(done), 64'd0);
   endtask

   initial begin
      vec_t        vecs[11];
      logic [63:0] m;
      logic [31:0] ra, rb;
      int          e;
      logic        seen;

      vecs[0]  = '{32'd7,          32'd2,          32'd3,          32'd1};
      vecs[1]  = '{32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF};
      vecs[2]  = '{32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1};
      vecs[3]  = '{32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0};
      vecs[4]  = '{32'd0,          32'd5,          32'd0,          32'd0};
      vecs[5]  = '{32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE};
      vecs[6]  = '{32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE};
      vecs[7]  = '{32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0};
      vecs[8]  = '{32'h80000000,   32'd1,          32'h80000000,   32'd0};
      vecs[9]  = '{32'h7FFFFFFF,   32'h80000000,   32'd0,          32'h7FFFFFFF};
      vecs[10] = '{32'd3,          32'd7,          32'd0,          32'd3};

      // reset held with start asserted: everything stays cleared
      a = 32'd7;
      b = 32'd2;
      start = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_divzero", 64'(divzero), 64'd0);
      check("rst_outputs", {hidiv, lodiv}, 64'd0);
      start = 1'b0;
      @(negedge clk);
      reset = 1'b1;

      foreach (vecs[i]) run_vec(vecs[i].va, vecs[i].vb, vecs[i].q, vecs[i].r);

      for (int i = 0; i < 25; i++) begin
         ra = $urandom;
         case ($urandom_range(0, 3))
            0:       rb = $urandom_range(1, 15);
            1:       rb = 32'd0 - $urandom_range(1, 15);
            default: rb = $urandom;
         endcase
         if (rb == 32'd0) rb = 32'd1;
         m = model(ra, rb);
         run_vec(ra, rb, m[31:0], m[63:32]);
      end

      // divide by zero after a completed 7/2
      run_vec(32'd7, 32'd2, 32'd3, 32'd1);
      issue(32'd5, 32'd0);
      check("dz_pulse", 64'(divzero), 64'd1);
      check("dz_busy", 64'(busy), 64'd0);
      check("dz_done", 64'(done), 64'd0);
      seen = 1'b0;
      @(posedge clk);
      #1;
      check("dz_one_cycle", 64'(divzero), 64'd0);
      repeat (40) begin
         @(posedge clk);
         #1 seen |= done | busy;
      end
      check("dz_no_done", 64'(seen), 64'd0);
      check("dz_retain", {hidiv, lodiv}, {32'd1, 32'd3});

      // ignored restart during CALC, operand changes, then back-to-back start on the done cycle
      issue(32'd100, 32'd7);
      repeat (3) @(posedge clk);
      @(negedge clk);
      a = 32'd1;
      b = 32'd1;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      a = 32'hDEADBEEF;
      b = 32'h00000003;
      wait_done(5, e);
      check("b2b_first_latency", 64'(e), 64'd34);
      check("b2b_first_result", {hidiv, lodiv}, {32'd2, 32'd14});
      @(negedge clk);
      a = 32'd9;
      b = 32'd3;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(1, e);
      check("b2b_second_latency", 64'(e), 64'd34);
      check("b2b_second_result", {hidiv, lodiv}, {32'd0, 32'd3});

      // reset mid-operation aborts without done
      issue(32'd100, 32'd7);
      repeat (8) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check("abort_outputs", {hidiv, lodiv}, 64'd0);
      @(negedge clk);
      reset = 1'b1;
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1 seen |= done | busy;
      end
      check("abort_no_done", 64'(seen), 64'd0);
      run_vec(32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no finish, expected finish before time limit");
      $fatal(1, "timeout");
   end

endmodule
